// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: state encoding, pin indices, default timing and helpers shared by the ext_bus_host slice
package ext_bus_pkg;

    localparam int DATA_W_DEF   = 34;
    localparam int PIN_OEB      = DATA_W_DEF;
    localparam int PIN_WEB      = DATA_W_DEF + 1;
    localparam int RD_WAIT_DEF  = 2;
    localparam int WR_PULSE_DEF = 1;
    localparam int TURN_DEF     = 1;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STROBE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_DONE,
        S_TURN
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/ext_bus_sync.sv
// ext_bus_sync: parameterised-width two-flop synchronizer, async active-high reset to 0
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   d_i    - asynchronous input bits
//   q_o    - synchronized output, two clk_i edges behind d_i
module ext_bus_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ext_bus_host.sv
// ext_bus_host: host initiator for the parallel pad bus (data, active-low OEb, active-low WEb)
// Ports:
//   clk_i, rst_i           - clock, asynchronous active-high reset
//   req_valid/req_ready    - request handshake, ready only while idle
//   req_we, req_wdata      - 1 = write of req_wdata, 0 = read
//   resp_valid, resp_rdata - one-cycle completion pulse, last read data (held)
//   busy                   - transaction or turnaround in progress
//   io_out, io_oeb, io_in  - pads: [DATA_W-1:0] data, [DATA_W] OEb, [DATA_W+1] WEb; io_oeb 0 = drive
// Build option: define EXT_BUS_HOST_SYNC_EN to pass read data through a 2-flop synchronizer;
// the read strobe is then lengthened by two cycles to cover the synchronizer delay.
module ext_bus_host
    import ext_bus_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_WAIT  = RD_WAIT_DEF,
    parameter int WR_PULSE = WR_PULSE_DEF,
    parameter int TURN     = TURN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [DATA_W+1:0] io_out,
    output logic [DATA_W+1:0] io_oeb,
    input  logic [DATA_W+1:0] io_in
);

    logic [DATA_W-1:0] rd_src;
    logic              unused_pins;

    assign unused_pins = ^io_in[DATA_W+1:DATA_W];

`ifdef EXT_BUS_HOST_SYNC_EN
    localparam int RD_LEN = RD_WAIT + SYNC_STAGES;

    ext_bus_sync #(.W(DATA_W)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (io_in[DATA_W-1:0]),
        .q_o   (rd_src)
    );
`else
    localparam int RD_LEN = RD_WAIT;

    assign rd_src = io_in[DATA_W-1:0];
`endif

    localparam int CNT_W = $clog2(max3(RD_LEN, WR_PULSE, TURN) + 1);
    localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_LEN - 1);
    localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN > 0) ? TURN - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              resp_valid_q, resp_valid_d;
    logic              oeb_q, oeb_d;
    logic              web_q, web_d;
    logic              drive_q, drive_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;

    assign accept = req_valid && ready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            oeb_q        <= 1'b1;
            web_q        <= 1'b1;
            drive_q      <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            oeb_q        <= oeb_d;
            web_q        <= web_d;
            drive_q      <= drive_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Timed states load cnt with (length-1) on entry and leave when it reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = req_we ? S_WR_SETUP : S_RD_STROBE;
                    cnt_d   = req_we ? '0 : RD_LD;
                end
            end
            S_RD_STROBE: state_d = (cnt_q == '0) ? S_DONE : S_RD_STROBE;
            S_WR_SETUP: begin
                state_d = S_WR_STROBE;
                cnt_d   = WR_LD;
            end
            S_WR_STROBE: state_d = (cnt_q == '0) ? S_WR_HOLD : S_WR_STROBE;
            S_WR_HOLD:   state_d = S_DONE;
            S_DONE: begin
                state_d = (TURN == 0) ? S_IDLE : S_TURN;
                cnt_d   = TURN_LD;
            end
            S_TURN:  state_d = (cnt_q == '0) ? S_IDLE : S_TURN;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        ready_d      = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_DONE);
        oeb_d        = (state_d != S_RD_STROBE);
        web_d        = (state_d != S_WR_STROBE);
        drive_d      = state_d inside {S_WR_SETUP, S_WR_STROBE, S_WR_HOLD};
        wdata_d      = (accept && req_we) ? req_wdata : wdata_q;
        rdata_d      = (state_q == S_RD_STROBE && cnt_q == '0) ? rd_src : rdata_q;
    end

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign io_out     = {web_q, oeb_q, wdata_q};
    assign io_oeb     = {2'b00, {DATA_W{~drive_q}}};

endmodule

// File: tb/tb_ext_bus_host.sv
// tb_ext_bus_host: directed self-checking bench for ext_bus_host (default and RD_WAIT=4/WR_PULSE=3/TURN=0 builds)
module tb_ext_bus_host;

    localparam int W = 34;
`ifdef EXT_BUS_HOST_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_valid = 1'b0, b_valid = 1'b0, req_we = 1'b0;
    logic [W-1:0] req_wdata = '0, rd_val = '0;
    logic         a_ready, a_resp, a_busy, b_ready, b_resp, b_busy;
    logic [W-1:0] a_rdata, b_rdata;
    logic [W+1:0] a_out, a_oeb, a_in, b_out, b_oeb, b_in;

    assign a_in = {2'b00, a_out[W] ? {W{1'b0}} : rd_val};
    assign b_in = {2'b00, b_out[W] ? {W{1'b0}} : rd_val};

    ext_bus_host u_a (
        .clk_i(clk), .rst_i(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(req_we),
        .req_wdata(req_wdata), .resp_valid(a_resp), .resp_rdata(a_rdata), .busy(a_busy),
        .io_out(a_out), .io_oeb(a_oeb), .io_in(a_in)
    );

    ext_bus_host #(.RD_WAIT(4), .WR_PULSE(3), .TURN(0)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(req_we),
        .req_wdata(req_wdata), .resp_valid(b_resp), .resp_rdata(b_rdata), .busy(b_busy),
        .io_out(b_out), .io_oeb(b_oeb), .io_in(b_in)
    );

    // Target devices: latch the data bus on every clock while WEb is low.
    logic [W-1:0] a_tgt = '0, b_tgt = '0;
    always @(posedge clk) begin
        if (!a_out[W+1]) a_tgt <= a_out[W-1:0];
        if (!b_out[W+1]) b_tgt <= b_out[W-1:0];
    end

    // Bus monitors: strobe/drive cycle counts and protocol violations.
    int   a_oel = 0, a_wel = 0, a_drv = 0, a_bad = 0;
    int   b_oel = 0, b_wel = 0, b_drv = 0, b_bad = 0;
    logic a_pw = 1'b1, a_pd = 1'b0, b_pw = 1'b1, b_pd = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            a_pw = 1'b1; a_pd = 1'b0; b_pw = 1'b1; b_pd = 1'b0;
        end else begin
            if (!a_out[W]) a_oel++;
            if (!a_out[W+1]) a_wel++;
            if (!a_oeb[0]) a_drv++;
            if (!a_out[W] && (!a_oeb[0] || !a_out[W+1])) a_bad++;
            if (!a_out[W+1] && !a_pd) a_bad++;
            if (a_out[W+1] && !a_pw && a_oeb[0]) a_bad++;
            a_pw = a_out[W+1]; a_pd = !a_oeb[0];
            if (!b_out[W]) b_oel++;
            if (!b_out[W+1]) b_wel++;
            if (!b_oeb[0]) b_drv++;
            if (!b_out[W] && (!b_oeb[0] || !b_out[W+1])) b_bad++;
            if (!b_out[W+1] && !b_pd) b_bad++;
            if (b_out[W+1] && !b_pw && b_oeb[0]) b_bad++;
            b_pw = b_out[W+1]; b_pd = !b_oeb[0];
        end
    end

    int passes = 0, fails = 0, total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request, wait for acceptance, then count cycles until resp_valid (-1 on timeout).
    task automatic issue(input bit s, input bit we, input logic [W-1:0] wd, output int lat);
        req_we = we;
        req_wdata = wd;
        if (s) b_valid = 1'b1; else a_valid = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (s ? b_ready : a_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (s ? b_resp : a_resp) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat, o0, w0, d0, n;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", a_ready, 1);
        chk("rst_resp_valid", a_resp, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_io_out", a_out, 36'hC_0000_0000);
        chk("rst_io_oeb", a_oeb, 36'h3_FFFF_FFFF);
        chk("rst_b_ready", b_ready, 1);

        rd_val = 34'h2_DEAD_BEEF;
        o0 = a_oel;
        issue(0, 0, '0, lat);
        chk("rd_latency", lat, 3 + SX);
        chk("rd_data", a_rdata, 34'h2_DEAD_BEEF);
        chk("rd_oeb_cycles", a_oel - o0, 2 + SX);
        @(negedge clk);
        chk("rd_resp_pulse", a_resp, 0);
        chk("rd_turn_ready", a_ready, 0);
        chk("rd_turn_released", a_oeb, 36'h3_FFFF_FFFF);
        @(negedge clk);
        chk("rd_idle_ready", a_ready, 1);

        w0 = a_wel;
        d0 = a_drv;
        issue(0, 1, 34'h1_2345_6789, lat);
        chk("wr_latency", lat, 4);
        chk("wr_target", a_tgt, 34'h1_2345_6789);
        chk("wr_web_cycles", a_wel - w0, 1);
        chk("wr_drive_cycles", a_drv - d0, 3);
        chk("wr_order_bad", a_bad, 0);
        @(negedge clk);
        @(negedge clk);

        // Back-to-back with req_valid held high across the turnaround.
        rd_val = 34'h1_0F0F_0F0F;
        req_we = 1'b1;
        req_wdata = 34'h0_5555_AAAA;
        a_valid = 1'b1;
        n = 0;
        while (!a_resp && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_wr_done", a_resp, 1);
        chk("b2b_wr_target", a_tgt, 34'h0_5555_AAAA);
        req_we = 1'b0;
        @(negedge clk);
        chk("b2b_turn_ready", a_ready, 0);
        chk("b2b_turn_released", a_oeb, 36'h3_FFFF_FFFF);
        chk("b2b_turn_oeb_pin", a_out[W], 1);
        @(negedge clk);
        chk("b2b_accept_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (a_resp) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk("b2b_rd_latency", lat, 3 + SX);
        chk("b2b_rd_data", a_rdata, 34'h1_0F0F_0F0F);
        @(negedge clk);
        @(negedge clk);

        rd_val = 34'h0_0000_00A5;
        issue(0, 0, '0, lat);
        chk("rdA5_latency", lat, 3 + SX);
        chk("rdA5_data", a_rdata, 34'h0_0000_00A5);
        @(negedge clk);
        @(negedge clk);

        // Reset asserted between clock edges while WEb is low.
        req_we = 1'b1;
        req_wdata = 34'h2_AAAA_5555;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        chk("mid_wr_web_low", a_out[W+1], 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_strobes", a_out[W+1:W], 2'b11);
        chk("arst_io_oeb", a_oeb, 36'h3_FFFF_FFFF);
        chk("arst_busy", a_busy, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", a_ready, 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_resp) n++;
            @(negedge clk);
        end
        chk("arst_no_resp", n, 0);

        rd_val = 34'h3_CAFE_F00D;
        o0 = b_oel;
        issue(1, 0, '0, lat);
        chk("b_rd_latency", lat, 5 + SX);
        chk("b_rd_data", b_rdata, 34'h3_CAFE_F00D);
        chk("b_rd_oeb_cycles", b_oel - o0, 4 + SX);
        @(negedge clk);
        chk("b_rd_ready_after_done", b_ready, 1);

        w0 = b_wel;
        d0 = b_drv;
        issue(1, 1, 34'h2_0000_0001, lat);
        chk("b_wr_latency", lat, 6);
        chk("b_wr_target", b_tgt, 34'h2_0000_0001);
        chk("b_wr_web_cycles", b_wel - w0, 3);
        chk("b_wr_drive_cycles", b_drv - d0, 5);
        @(negedge clk);
        chk("b_wr_ready_after_done", b_ready, 1);

        chk("a_protocol_bad", a_bad, 0);
        chk("b_protocol_bad", b_bad, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
